// File: rtl/accel_bus_pkg.sv
// Shared constants and types for the CPU accelerator bus slave.
// Covers bus encodings, the register map, CTRL/STATUS bit positions and the FSM state type.
package accel_bus_pkg;

    localparam logic [1:0] RDWR_RD = 2'b10;
    localparam logic [1:0] RDWR_WR = 2'b01;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_SRC    = 3'd2;
    localparam logic [2:0] REG_DST    = 3'd3;
    localparam logic [2:0] REG_LEN    = 3'd4;
    localparam logic [2:0] REG_WGT    = 3'd5;
    localparam logic [2:0] REG_RESULT = 3'd6;
    localparam logic [2:0] REG_ID     = 3'd7;

    localparam int CTRL_GO  = 0;
    localparam int CTRL_IE  = 1;
    localparam int CTRL_CLR = 2;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR_ACK,
        ST_RD_LATCH,
        ST_RD_ACK
    } bus_state_e;

endpackage

// File: rtl/accel_bus_slave_if.sv
// CPU-side accelerator bus: transaction strobes, address, data in both directions and the done pulse.
interface accel_bus_slave_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic              bus_en;
    logic              bus_start;
    logic [1:0]        bus_rdwr;
    logic [ADDR_W-1:0] bus_regaddr;
    logic [DATA_W-1:0] bus_data_in;
    logic [DATA_W-1:0] bus_data_out;
    logic              bus_data_oe;
    logic              bus_done;

    modport master (
        output bus_en, bus_start, bus_rdwr, bus_regaddr, bus_data_in,
        input  bus_data_out, bus_data_oe, bus_done
    );

    modport slave (
        input  bus_en, bus_start, bus_rdwr, bus_regaddr, bus_data_in,
        output bus_data_out, bus_data_oe, bus_done
    );
endinterface

// File: rtl/accel_regfile.sv
// Register storage for the accelerator slave: write decode, read mux and the sticky
// done/err status bits fed by the accelerator completion pulse.
module accel_regfile
    import accel_bus_pkg::*;
#(
    parameter int              DATA_W   = 16,
    parameter int              ADDR_W   = 3,
    parameter logic [DATA_W-1:0] ID_VALUE = 16'hACC1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              err_set_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic              acc_busy_i,
    input  logic              acc_done_i,
    input  logic [DATA_W-1:0] acc_result_i,
    output logic              go_fire_o,
    output logic [DATA_W-1:0] src_o,
    output logic [DATA_W-1:0] dst_o,
    output logic [DATA_W-1:0] len_o,
    output logic [DATA_W-1:0] wgt_o,
    output logic              irq_o
);

    logic [DATA_W-1:0] src_q, src_d;
    logic [DATA_W-1:0] dst_q, dst_d;
    logic [DATA_W-1:0] len_q, len_d;
    logic [DATA_W-1:0] wgt_q, wgt_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              ie_q, ie_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic ctrl_wr;
    logic go_write;
    logic clr_write;

    assign ctrl_wr   = wr_en_i && (wr_addr_i == REG_CTRL);
    assign go_write  = ctrl_wr && wr_data_i[CTRL_GO];
    assign clr_write = ctrl_wr && wr_data_i[CTRL_CLR];
    // A GO while the core is still running is refused and flagged instead of launched.
    assign go_fire_o = go_write && !acc_busy_i;

    always_comb begin
        src_d    = src_q;
        dst_d    = dst_q;
        len_d    = len_q;
        wgt_d    = wgt_q;
        ie_d     = ie_q;
        result_d = result_q;
        done_d   = done_q;
        err_d    = err_q;

        if (wr_en_i) begin
            case (wr_addr_i)
                REG_CTRL: ie_d  = wr_data_i[CTRL_IE];
                REG_SRC:  src_d = wr_data_i;
                REG_DST:  dst_d = wr_data_i;
                REG_LEN:  len_d = wr_data_i;
                REG_WGT:  wgt_d = wr_data_i;
                default:  ;
            endcase
        end

        // Setting beats clearing so a completion racing a CLR is never lost.
        if (acc_done_i) begin
            result_d = acc_result_i;
            done_d   = 1'b1;
        end else if (clr_write) begin
            done_d = 1'b0;
        end

        if (err_set_i || (go_write && acc_busy_i)) begin
            err_d = 1'b1;
        end else if (clr_write) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            wgt_q    <= '0;
            result_q <= '0;
            ie_q     <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            src_q    <= src_d;
            dst_q    <= dst_d;
            len_q    <= len_d;
            wgt_q    <= wgt_d;
            result_q <= result_d;
            ie_q     <= ie_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        rd_data_o = '0;
        case (rd_addr_i)
            REG_CTRL:   rd_data_o[CTRL_IE] = ie_q;
            REG_STATUS: begin
                rd_data_o[STAT_BUSY] = acc_busy_i;
                rd_data_o[STAT_DONE] = done_q;
                rd_data_o[STAT_ERR]  = err_q;
            end
            REG_SRC:    rd_data_o = src_q;
            REG_DST:    rd_data_o = dst_q;
            REG_LEN:    rd_data_o = len_q;
            REG_WGT:    rd_data_o = wgt_q;
            REG_RESULT: rd_data_o = result_q;
            REG_ID:     rd_data_o = ID_VALUE;
            default:    rd_data_o = '0;
        endcase
    end

    assign src_o = src_q;
    assign dst_o = dst_q;
    assign len_o = len_q;
    assign wgt_o = wgt_q;
    assign irq_o = done_q && ie_q;

endmodule

// File: rtl/accel_bus_slave.sv
// Register-mapped CPU bus slave in front of the NN accelerator core: bus transaction FSM
// plus the go/done handshake, with register storage delegated to accel_regfile.
module accel_bus_slave
    import accel_bus_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 3,
    parameter logic [DATA_W-1:0] ID_VALUE = 16'hACC1
) (
    input  logic              clk,
    input  logic              rst,
    accel_bus_slave_if.slave  bus,
    output logic              acc_go,
    input  logic              acc_busy,
    input  logic              acc_done,
    input  logic [DATA_W-1:0] acc_result,
    output logic [DATA_W-1:0] acc_src,
    output logic [DATA_W-1:0] acc_dst,
    output logic [DATA_W-1:0] acc_len,
    output logic [DATA_W-1:0] acc_wgt,
    output logic              irq
);

    bus_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic              go_pend_q, go_pend_d;

    logic              accept;
    logic              is_rd;
    logic              is_wr;
    logic              wr_en;
    logic              illegal;
    logic              go_fire;
    logic [DATA_W-1:0] rf_rd_data;

    assign accept  = (state_q == ST_IDLE) && bus.bus_start && bus.bus_en;
    assign is_rd   = (bus.bus_rdwr == RDWR_RD);
    assign is_wr   = (bus.bus_rdwr == RDWR_WR);
    assign wr_en   = accept && is_wr;
    assign illegal = accept && !is_rd && !is_wr;

    accel_regfile #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ID_VALUE (ID_VALUE)
    ) u_regfile (
        .clk          (clk),
        .rst          (rst),
        .wr_en_i      (wr_en),
        .wr_addr_i    (bus.bus_regaddr),
        .wr_data_i    (bus.bus_data_in),
        .err_set_i    (illegal),
        .rd_addr_i    (addr_q),
        .rd_data_o    (rf_rd_data),
        .acc_busy_i   (acc_busy),
        .acc_done_i   (acc_done),
        .acc_result_i (acc_result),
        .go_fire_o    (go_fire),
        .src_o        (acc_src),
        .dst_o        (acc_dst),
        .len_o        (acc_len),
        .wgt_o        (acc_wgt),
        .irq_o        (irq)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            rd_q      <= '0;
            go_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rd_q      <= rd_d;
            go_pend_q <= go_pend_d;
        end
    end

    // Illegal rdwr codes still take the write-ack path so the CPU always sees a done.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rd_d      = rd_q;
        go_pend_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_rd) begin
                        addr_d  = bus.bus_regaddr;
                        state_d = ST_RD_LATCH;
                    end else begin
                        go_pend_d = go_fire;
                        state_d   = ST_WR_ACK;
                    end
                end
            end
            ST_WR_ACK: state_d = ST_IDLE;
            ST_RD_LATCH: begin
                rd_d    = rf_rd_data;
                state_d = bus.bus_en ? ST_RD_ACK : ST_IDLE;
            end
            ST_RD_ACK: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Dropping bus_en mid-transaction suppresses done/oe; a committed GO still launches.
    always_comb begin
        bus.bus_done     = 1'b0;
        bus.bus_data_oe  = 1'b0;
        bus.bus_data_out = '0;
        acc_go           = 1'b0;
        case (state_q)
            ST_WR_ACK: begin
                bus.bus_done = bus.bus_en;
                acc_go       = go_pend_q;
            end
            ST_RD_ACK: begin
                bus.bus_done     = bus.bus_en;
                bus.bus_data_oe  = bus.bus_en;
                bus.bus_data_out = bus.bus_en ? rd_q : '0;
            end
            default: ;
        endcase
    end

endmodule
